ps2_line_buf: RTL and testbench



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_ram.sv | 31 +++
 rtl/ps2_line_buf.sv | 167 ++++++++++++++++
 tb/tb_ps2_line_buf.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 line buffer.
//   ASCII/scan constants, keyboard and line status bit indices, FSM enum.
package ps2_pkg;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_BS     = 8'h08;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] PS2_UNMAPPED = 8'h23;

    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned LS_READY   = 0;
    localparam int unsigned LS_OVF     = 1;
    localparam int unsigned LS_LEN_LSB = 8;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        SETTLE,
        PROC,
        DONE
    } state_t;

endpackage

// File: rtl/ps2_line_ram.sv
// DEPTH x 8 line storage: one synchronous write port, one asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write byte
//   raddr : read address
//   rdata : byte at raddr (combinational)
module ps2_line_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ps2_line_buf.sv
// Line-assembly buffer between the PS/2 keyboard ASCII FIFO and the CPU bus.
// Drains the keyboard FIFO, drops break sequences and unmapped keys, applies
// backspace editing, and on Enter exposes the finished line for per-char reads.
//   clk         : system clock
//   rst         : asynchronous reset, active-low
//   kb_status   : keyboard FIFO status (bit0 empty, bit1 full)
//   kb_data     : keyboard FIFO head byte in [7:0]
//   kb_rd       : one-cycle pop strobe to the keyboard FIFO
//   line_rd     : CPU pop strobe for the completed line
//   line_status : bit0 ready, bit1 overflow, [15:8] length/remaining
//   line_data   : character at the read pointer while ready, else 0
// Optional macro PS2_LINE_ECHO_EN adds echo_valid/echo_char for a text console.
module ps2_line_buf
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] kb_status,
    input  logic [31:0] kb_data,
    output logic        kb_rd,
    input  logic        line_rd,
    output logic [31:0] line_status,
    output logic [31:0] line_data
`ifdef PS2_LINE_ECHO_EN
    ,
    output logic        echo_valid,
    output logic [7:0]  echo_char
`endif
);

    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

    state_t          state;
    logic [7:0]      byte_q;
    logic            brk;
    logic            ready;
    logic            ovf;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [LW-1:0]   len;
    logic [7:0]      rd_char;

    logic            in_proc;
    logic            is_ctrl;
    logic            store_en;
    logic            bs_en;

    logic            unused_inputs;
    assign unused_inputs = ^{kb_status[31:1], kb_data[31:8]};

    // Classification of the captured byte while in PROC (break-follow first).
    assign in_proc  = (state == PROC) && !brk;
    assign is_ctrl  = (byte_q == PS2_BRK) || (byte_q == PS2_UNMAPPED) ||
                      (byte_q == ASCII_BS) || (byte_q == ASCII_CR);
    assign store_en = in_proc && !is_ctrl && (len != LEN_MAX);
    assign bs_en    = in_proc && (byte_q == ASCII_BS) && (len != '0);

    ps2_line_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (store_en),
        .waddr (wptr),
        .wdata (byte_q),
        .raddr (rptr),
        .rdata (rd_char)
    );

    // Intake / edit / drain state machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            kb_rd  <= 1'b0;
            byte_q <= 8'h00;
            brk    <= 1'b0;
            ready  <= 1'b0;
            ovf    <= 1'b0;
            wptr   <= '0;
            rptr   <= '0;
            len    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!kb_status[ST_EMPTY]) begin
                        state <= POP;
                        kb_rd <= 1'b1;
                    end
                end
                POP: begin
                    kb_rd  <= 1'b0;
                    byte_q <= kb_data[7:0];
                    state  <= SETTLE;
                end
                SETTLE: begin
                    state <= PROC;
                end
                PROC: begin
                    state <= IDLE;
                    if (brk) begin
                        brk <= 1'b0;
                    end else if (byte_q == PS2_BRK) begin
                        brk <= 1'b1;
                    end else if (byte_q == PS2_UNMAPPED) begin
                        brk <= 1'b0;
                    end else if (byte_q == ASCII_BS) begin
                        if (len != '0) begin
                            len  <= len - LW'(1);
                            wptr <= wptr - AW'(1);
                        end
                    end else if (byte_q == ASCII_CR) begin
                        if (len != '0) begin
                            ready <= 1'b1;
                            rptr  <= '0;
                            state <= DONE;
                        end
                    end else if (len != LEN_MAX) begin
                        wptr <= wptr + AW'(1);
                        len  <= len + LW'(1);
                    end else begin
                        ovf <= 1'b1;
                    end
                end
                DONE: begin
                    if (line_rd && ready) begin
                        rptr <= rptr + AW'(1);
                        len  <= len - LW'(1);
                        // Last character leaves: release the line and resume intake.
                        if (len == LW'(1)) begin
                            ready <= 1'b0;
                            ovf   <= 1'b0;
                            wptr  <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    kb_rd <= 1'b0;
                end
            endcase
        end
    end

    // Status/data views of the registered line state.
    always_comb begin
        line_status                     = '0;
        line_status[LS_READY]           = ready;
        line_status[LS_OVF]             = ovf;
        line_status[LS_LEN_LSB +: 8]    = 8'(len);
    end

    assign line_data = ready ? {24'h0, rd_char} : 32'h0;

`ifdef PS2_LINE_ECHO_EN
    assign echo_valid = store_en || bs_en;
    assign echo_char  = bs_en ? ASCII_BS : byte_q;
`else
    logic unused_bs;
    assign unused_bs = bs_en;
`endif

endmodule

// File: tb/tb_ps2_line_buf.sv
// Scoreboard bench for ps2_line_buf: keyboard FIFO model feeds directed bytes,
// expected line characters are queued and checked by a separate monitor.
module tb_ps2_line_buf;

    logic        clk;
    logic        rst;
    logic [31:0] kb_status;
    logic [31:0] kb_data;
    logic        kb_rd;
    logic        line_rd;
    logic [31:0] line_status;
    logic [31:0] line_data;
`ifdef PS2_LINE_ECHO_EN
    logic        echo_valid;
    logic [7:0]  echo_char;
`endif

    int          n_chk;
    int          n_pass;
    int          kb_pulses;
    logic [7:0]  kb_q[$];
    logic [7:0]  exp_q[$];
    bit          prev_rd;

    ps2_line_buf #(
        .DEPTH (32),
        .AW    (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .kb_status   (kb_status),
        .kb_data     (kb_data),
        .kb_rd       (kb_rd),
        .line_rd     (line_rd),
        .line_status (line_status),
        .line_data   (line_data)
`ifdef PS2_LINE_ECHO_EN
        ,
        .echo_valid  (echo_valid),
        .echo_char   (echo_char)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Keyboard FIFO model: pop one cycle after the strobe is seen, so the
    // head byte is stable across the edge where the DUT captures it.
    always @(negedge clk) begin
        if (!rst) begin
            prev_rd = 1'b0;
        end else begin
            if (prev_rd && kb_q.size() > 0) void'(kb_q.pop_front());
            prev_rd = kb_rd;
            if (kb_rd) kb_pulses++;
        end
        kb_status = {30'h0, 1'b0, (kb_q.size() == 0)};
        kb_data   = {24'h0, (kb_q.size() > 0) ? kb_q[0] : 8'h00};
    end

    // Monitor: every accepted line read is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst && line_rd && line_status[0]) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_char: got 0x%08h expected none", line_data);
            end else begin
                check("line_char", line_data, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic feed(input logic [7:0] b);
        kb_q.push_back(b);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (kb_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d bytes left expected 0", kb_q.size());
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic rd_one();
        @(posedge clk);
        #1 line_rd = 1'b1;
        @(posedge clk);
        #1 line_rd = 1'b0;
    endtask

    task automatic expect_read(input logic [7:0] c);
        exp_q.push_back(c);
        rd_one();
    endtask

    int p0;

    initial begin
        n_chk = 0; n_pass = 0; kb_pulses = 0;
        rst = 1'b0; line_rd = 1'b0;
        kb_status = 32'h1; kb_data = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_status", line_status, 32'h0);
        check("reset_data", line_data, 32'h0);
        check("reset_kb_rd", {31'h0, kb_rd}, 32'h0);
        rst = 1'b1;

        // "HI" + Enter
        p0 = kb_pulses;
        feed(8'h48); feed(8'h49); feed(8'h0D);
        wait_drain();
        check("hi_pulses", kb_pulses - p0, 3);
        check("hi_status", line_status, 32'h0000_0201);
        expect_read(8'h48);
        @(negedge clk);
        check("hi_status_mid", line_status, 32'h0000_0101);
        expect_read(8'h49);
        @(negedge clk);
        check("hi_status_end", line_status, 32'h0);

        // Break sequence discards the released key
        feed(8'h41); feed(8'hF0); feed(8'h41); feed(8'h0D);
        wait_drain();
        check("brk_status", line_status, 32'h0000_0101);
        expect_read(8'h41);
        @(negedge clk);
        check("brk_status_end", line_status, 32'h0);

        // Backspace editing, leading and surplus backspaces ignored
        feed(8'h08); feed(8'h41); feed(8'h42); feed(8'h08);
        feed(8'h08); feed(8'h08); feed(8'h43); feed(8'h0D);
        wait_drain();
        check("bs_status", line_status, 32'h0000_0101);
        expect_read(8'h43);

        // Unmapped marker, then lone Enter with empty line is ignored
        feed(8'h23); feed(8'h0D);
        wait_drain();
        check("empty_enter", line_status, 32'h0);

        // Overflow: 33 chars into a 32-deep line
        for (int i = 0; i < 33; i++) feed(8'h31);
        feed(8'h0D);
        wait_drain();
        check("ovf_status", line_status, 32'h0000_2003);
        for (int i = 0; i < 31; i++) expect_read(8'h31);
        @(negedge clk);
        check("ovf_status_last", line_status, 32'h0000_0103);
        expect_read(8'h31);
        @(negedge clk);
        check("ovf_status_end", line_status, 32'h0);

        // No intake while a line is pending
        feed(8'h4B); feed(8'h0D);
        wait_drain();
        p0 = kb_pulses;
        feed(8'h4D);
        repeat (20) @(negedge clk);
        check("done_no_pop", kb_pulses - p0, 0);
        check("done_status", line_status, 32'h0000_0101);
        expect_read(8'h4B);
        wait_drain();
        check("resume_status", line_status, 32'h0000_0100);
        rd_one();
        @(negedge clk);
        check("idle_rd_status", line_status, 32'h0000_0100);
        check("idle_rd_data", line_data, 32'h0);
        feed(8'h0D);
        wait_drain();
        check("resume_ready", line_status, 32'h0000_0101);
        expect_read(8'h4D);

        // Reset in the middle of a pending line
        feed(8'h41); feed(8'h42); feed(8'h43); feed(8'h44); feed(8'h45); feed(8'h0D);
        wait_drain();
        check("pre_rst_status", line_status, 32'h0000_0501);
        check("pre_rst_data", line_data, 32'h0000_0041);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_status", line_status, 32'h0);
        check("async_rst_data", line_data, 32'h0);
        check("async_rst_kb_rd", {31'h0, kb_rd}, 32'h0);
        kb_q.delete();
        @(negedge clk);
        rst = 1'b1;
        feed(8'h5A); feed(8'h0D);
        wait_drain();
        check("post_rst_status", line_status, 32'h0000_0101);
        expect_read(8'h5A);
        @(negedge clk);
        check("post_rst_end", line_status, 32'h0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
